// File: rtl/cardinal_nic_fifo_if.sv
// Processor register port plus ring-router local port of the Cardinal NIC.
// The slave modport is the NIC side; the master modport drives it.
interface cardinal_nic_fifo_if #(
    parameter int DATA_W = 64
);
    logic [0:1]        addr;
    logic [0:DATA_W-1] d_in;
    logic [0:DATA_W-1] d_out;
    logic              nicEn;
    logic              nicWrEn;
    logic              net_si;
    logic              net_ri;
    logic [0:DATA_W-1] net_di;
    logic              net_so;
    logic              net_ro;
    logic [0:DATA_W-1] net_do;
    logic              net_polarity;

    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );

    modport master (
        output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/cardinal_nic_fifo.sv
// Cardinal NIC with FIFO-buffered input (router->CPU) and output (CPU->router)
// channels, occupancy/sticky-error status registers and polarity-gated injection.
module cardinal_nic_fifo #(
    parameter int DATA_W    = 64,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    cardinal_nic_fifo_if.slave bus
);
    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int IN_CW  = IN_AW + 1;
    localparam int OUT_CW = OUT_AW + 1;
    localparam logic [IN_CW-1:0]  IN_FULL_CNT  = IN_CW'(IN_DEPTH);
    localparam logic [OUT_CW-1:0] OUT_FULL_CNT = OUT_CW'(OUT_DEPTH);

    logic [0:DATA_W-1] in_mem  [IN_DEPTH];
    logic [0:DATA_W-1] out_mem [OUT_DEPTH];

    logic [IN_AW-1:0]  in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
    logic [IN_CW-1:0]  in_cnt_q, in_cnt_d;
    logic              in_ufl_q, in_ufl_d;
    logic [OUT_AW-1:0] out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
    logic [OUT_CW-1:0] out_cnt_q, out_cnt_d;
    logic              out_ovf_q, out_ovf_d;
    logic [0:DATA_W-1] d_out_q, d_out_d;

    logic in_full, in_nonempty, out_full, out_nonempty;
    logic cpu_rd, cpu_wr, in_push, in_pop, out_push, out_pop;
    logic [0:DATA_W-1] out_head;

    function automatic logic [0:DATA_W-1] status_word(input logic flag,
                                                      input logic sticky,
                                                      input logic [7:0] cnt);
        logic [0:DATA_W-1] w;
        w             = '0;
        w[DATA_W-1]   = flag;
        w[DATA_W-2]   = sticky;
        w[32:39]      = cnt;
        return w;
    endfunction

    assign in_full      = (in_cnt_q == IN_FULL_CNT);
    assign in_nonempty  = (in_cnt_q != '0);
    assign out_full     = (out_cnt_q == OUT_FULL_CNT);
    assign out_nonempty = (out_cnt_q != '0);
    assign out_head     = out_mem[out_rd_ptr_q];

    assign cpu_rd   = bus.nicEn & ~bus.nicWrEn;
    assign cpu_wr   = bus.nicEn & bus.nicWrEn;
    assign in_push  = bus.net_si & ~in_full;
    assign in_pop   = cpu_rd & (bus.addr == 2'b00) & in_nonempty;
    assign out_pop  = bus.net_so;
    // A write into a full FIFO still lands if the head leaves on the same edge.
    assign out_push = cpu_wr & (bus.addr == 2'b10) & (~out_full | out_pop);

    assign bus.net_ri = ~in_full;
    assign bus.net_so = out_nonempty & bus.net_ro & (out_head[0] == bus.net_polarity);
    assign bus.net_do = out_nonempty ? out_head : '0;
    assign bus.d_out  = d_out_q;

    always_comb begin
        in_wr_ptr_d  = in_push  ? in_wr_ptr_q  + IN_AW'(1)  : in_wr_ptr_q;
        in_rd_ptr_d  = in_pop   ? in_rd_ptr_q  + IN_AW'(1)  : in_rd_ptr_q;
        out_wr_ptr_d = out_push ? out_wr_ptr_q + OUT_AW'(1) : out_wr_ptr_q;
        out_rd_ptr_d = out_pop  ? out_rd_ptr_q + OUT_AW'(1) : out_rd_ptr_q;
        in_cnt_d     = in_cnt_q  + IN_CW'(in_push)   - IN_CW'(in_pop);
        out_cnt_d    = out_cnt_q + OUT_CW'(out_push) - OUT_CW'(out_pop);
        in_ufl_d     = in_ufl_q;
        out_ovf_d    = out_ovf_q;
        d_out_d      = d_out_q;

        if (cpu_rd) begin
            unique case (bus.addr)
                2'b00: begin
                    d_out_d = in_nonempty ? in_mem[in_rd_ptr_q] : '0;
                    if (!in_nonempty) in_ufl_d = 1'b1;
                end
                // Status reads report the sticky bit as it was, then clear it.
                2'b01: begin
                    d_out_d  = status_word(in_nonempty, in_ufl_q, 8'(in_cnt_q));
                    in_ufl_d = 1'b0;
                end
                2'b10: d_out_d = '0;
                2'b11: begin
                    d_out_d   = status_word(out_full, out_ovf_q, 8'(out_cnt_q));
                    out_ovf_d = 1'b0;
                end
                default: d_out_d = '0;
            endcase
        end

        if (cpu_wr && bus.addr == 2'b10 && !out_push) out_ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (in_push)  in_mem[in_wr_ptr_q]   <= bus.net_di;
        if (out_push) out_mem[out_wr_ptr_q] <= bus.d_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_wr_ptr_q  <= '0;
            in_rd_ptr_q  <= '0;
            in_cnt_q     <= '0;
            in_ufl_q     <= 1'b0;
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            out_cnt_q    <= '0;
            out_ovf_q    <= 1'b0;
            d_out_q      <= '0;
        end else begin
            in_wr_ptr_q  <= in_wr_ptr_d;
            in_rd_ptr_q  <= in_rd_ptr_d;
            in_cnt_q     <= in_cnt_d;
            in_ufl_q     <= in_ufl_d;
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            out_cnt_q    <= out_cnt_d;
            out_ovf_q    <= out_ovf_d;
            d_out_q      <= d_out_d;
        end
    end
endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// Directed bench for cardinal_nic_fifo (DATA_W=64, both depths 4).
// Inputs change 1ns after each rising edge; outputs are checked in that window.
module tb_cardinal_nic_fifo;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    cardinal_nic_fifo_if #(.DATA_W(64)) bus ();

    cardinal_nic_fifo #(.DATA_W(64), .IN_DEPTH(4), .OUT_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [0:63] stat(input logic flag, input logic sticky, input logic [7:0] cnt);
        logic [0:63] s;
        s        = '0;
        s[63]    = flag;
        s[62]    = sticky;
        s[32:39] = cnt;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.nicEn   = 1'b0;
        bus.nicWrEn = 1'b0;
        bus.addr    = 2'b00;
        bus.d_in    = '0;
        bus.net_si  = 1'b0;
        bus.net_di  = '0;
    endtask

    task automatic cpu_read(input logic [0:1] a, output logic [0:63] data);
        bus.nicEn = 1'b1; bus.nicWrEn = 1'b0; bus.addr = a;
        tick();
        bus.nicEn = 1'b0;
        data = bus.d_out;
        $display("read  addr=%b -> %h", a, data);
    endtask

    task automatic cpu_write(input logic [0:1] a, input logic [0:63] data);
        bus.nicEn = 1'b1; bus.nicWrEn = 1'b1; bus.addr = a; bus.d_in = data;
        tick();
        bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
        $display("write addr=%b <- %h", a, data);
    endtask

    task automatic router_push(input logic [0:63] data);
        bus.net_si = 1'b1; bus.net_di = data;
        tick();
        bus.net_si = 1'b0;
        $display("push  %h", data);
    endtask

    task automatic test_reset();
        logic [0:63] r;
        reset = 1'b1; bus.net_ro = 1'b0; bus.net_polarity = 1'b0; idle();
        tick(); tick();
        reset = 1'b0;
        vectors++; if (bus.net_ri !== 1'b1) begin miscompares++; $display("FAIL reset_ri got=%b exp=1", bus.net_ri); end
        vectors++; if (bus.net_so !== 1'b0) begin miscompares++; $display("FAIL reset_so got=%b exp=0", bus.net_so); end
        vectors++; if (bus.net_do !== 64'h0) begin miscompares++; $display("FAIL reset_do got=%h exp=0", bus.net_do); end
        vectors++; if (bus.d_out !== 64'h0) begin miscompares++; $display("FAIL reset_dout got=%h exp=0", bus.d_out); end
        cpu_read(2'b01, r);
        vectors++; if (r !== 64'h0) begin miscompares++; $display("FAIL reset_in_status got=%h exp=0", r); end
        cpu_read(2'b11, r);
        vectors++; if (r !== 64'h0) begin miscompares++; $display("FAIL reset_out_status got=%h exp=0", r); end
    endtask

    task automatic test_input_fill();
        logic [0:63] r;
        for (int i = 1; i <= 4; i++) begin
            vectors++; if (bus.net_ri !== 1'b1) begin miscompares++; $display("FAIL fill_ri_%0d got=%b exp=1", i, bus.net_ri); end
            router_push(64'(i));
        end
        vectors++; if (bus.net_ri !== 1'b0) begin miscompares++; $display("FAIL full_ri got=%b exp=0", bus.net_ri); end
        cpu_read(2'b01, r);
        vectors++; if (r !== stat(1'b1, 1'b0, 8'd4)) begin miscompares++; $display("FAIL full_status got=%h exp=%h", r, stat(1'b1, 1'b0, 8'd4)); end
        for (int i = 1; i <= 4; i++) begin
            cpu_read(2'b00, r);
            vectors++; if (r !== 64'(i)) begin miscompares++; $display("FAIL in_order_%0d got=%h exp=%h", i, r, 64'(i)); end
        end
        cpu_read(2'b00, r);
        vectors++; if (r !== 64'h0) begin miscompares++; $display("FAIL underflow_data got=%h exp=0", r); end
        cpu_read(2'b01, r);
        vectors++; if (r !== stat(1'b0, 1'b1, 8'd0)) begin miscompares++; $display("FAIL ufl_set got=%h exp=%h", r, stat(1'b0, 1'b1, 8'd0)); end
        cpu_read(2'b01, r);
        vectors++; if (r !== 64'h0) begin miscompares++; $display("FAIL ufl_clear got=%h exp=0", r); end
    endtask

    task automatic test_inject();
        logic [0:63] w;
        logic [0:63] r;
        w = 64'h0123_4567_89ab_cdef;
        w[0] = 1'b1;
        bus.net_ro = 1'b1; bus.net_polarity = 1'b0;
        cpu_write(2'b10, w);
        vectors++; if (bus.net_so !== 1'b0) begin miscompares++; $display("FAIL inj_wrong_pol got=%b exp=0", bus.net_so); end
        vectors++; if (bus.net_do !== w) begin miscompares++; $display("FAIL inj_do got=%h exp=%h", bus.net_do, w); end
        tick();
        bus.net_polarity = 1'b1;
        #1;
        vectors++; if (bus.net_so !== 1'b1) begin miscompares++; $display("FAIL inj_so got=%b exp=1", bus.net_so); end
        tick();
        bus.net_polarity = 1'b0; bus.net_ro = 1'b0;
        $display("inject done do=%h", bus.net_do);
        vectors++; if (bus.net_do !== 64'h0) begin miscompares++; $display("FAIL inj_empty_do got=%h exp=0", bus.net_do); end
        cpu_read(2'b11, r);
        vectors++; if (r !== 64'h0) begin miscompares++; $display("FAIL inj_status got=%h exp=0", r); end
    endtask

    task automatic test_out_full();
        logic [0:63] r;
        logic [0:63] exp_q [$];
        bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_write(2'b10, 64'h10 + 64'(i));
            exp_q.push_back(64'h10 + 64'(i));
        end
        cpu_write(2'b10, 64'h14);
        cpu_read(2'b11, r);
        vectors++; if (r !== stat(1'b1, 1'b1, 8'd4)) begin miscompares++; $display("FAIL ovf_set got=%h exp=%h", r, stat(1'b1, 1'b1, 8'd4)); end
        bus.net_ro = 1'b1;
        bus.nicEn = 1'b1; bus.nicWrEn = 1'b1; bus.addr = 2'b10; bus.d_in = 64'h15;
        #1;
        vectors++; if (bus.net_so !== 1'b1) begin miscompares++; $display("FAIL full_pop_so got=%b exp=1", bus.net_so); end
        tick();
        bus.nicEn = 1'b0; bus.nicWrEn = 1'b0; bus.net_ro = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(64'h15);
        $display("write addr=10 <- %h with injection", 64'h15);
        cpu_read(2'b11, r);
        vectors++; if (r !== stat(1'b1, 1'b0, 8'd4)) begin miscompares++; $display("FAIL full_swap_status got=%h exp=%h", r, stat(1'b1, 1'b0, 8'd4)); end
        bus.net_ro = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (bus.net_do !== exp_q[i] || bus.net_so !== 1'b1) begin miscompares++; $display("FAIL drain_%0d got=%h so=%b exp=%h", i, bus.net_do, bus.net_so, exp_q[i]); end
            tick();
            $display("inject %h", exp_q[i]);
        end
        bus.net_ro = 1'b0;
        vectors++; if (bus.net_do !== 64'h0) begin miscompares++; $display("FAIL drain_empty got=%h exp=0", bus.net_do); end
    endtask

    task automatic test_back_to_back();
        logic [0:63] r;
        router_push(64'd100);
        router_push(64'd101);
        for (int k = 0; k < 8; k++) begin
            bus.net_si = 1'b1; bus.net_di = 64'(102 + k);
            bus.nicEn = 1'b1; bus.nicWrEn = 1'b0; bus.addr = 2'b00;
            tick();
            $display("push %0d + read -> %0d", 102 + k, bus.d_out);
            vectors++; if (bus.d_out !== 64'(100 + k)) begin miscompares++; $display("FAIL b2b_%0d got=%0d exp=%0d", k, bus.d_out, 100 + k); end
        end
        idle();
        cpu_read(2'b01, r);
        vectors++; if (r !== stat(1'b1, 1'b0, 8'd2)) begin miscompares++; $display("FAIL b2b_count got=%h exp=%h", r, stat(1'b1, 1'b0, 8'd2)); end
        for (int k = 8; k < 10; k++) begin
            cpu_read(2'b00, r);
            vectors++; if (r !== 64'(100 + k)) begin miscompares++; $display("FAIL b2b_tail_%0d got=%0d exp=%0d", k, r, 100 + k); end
        end
    endtask

    task automatic test_reset_mid();
        logic [0:63] r;
        logic [0:63] w;
        bus.net_ro = 1'b0; bus.net_polarity = 1'b1;
        for (int i = 0; i < 3; i++) begin
            router_push(64'h200 + 64'(i));
            w = 64'h300 + 64'(i);
            w[0] = 1'b1;
            cpu_write(2'b10, w);
        end
        cpu_read(2'b00, r);
        router_push(64'h203);
        reset = 1'b1;
        tick();
        reset = 1'b0; bus.net_ro = 1'b1;
        #1;
        $display("reset with queued packets");
        vectors++; if (bus.net_so !== 1'b0) begin miscompares++; $display("FAIL mid_so got=%b exp=0", bus.net_so); end
        vectors++; if (bus.net_ri !== 1'b1) begin miscompares++; $display("FAIL mid_ri got=%b exp=1", bus.net_ri); end
        vectors++; if (bus.net_do !== 64'h0) begin miscompares++; $display("FAIL mid_do got=%h exp=0", bus.net_do); end
        vectors++; if (bus.d_out !== 64'h0) begin miscompares++; $display("FAIL mid_dout got=%h exp=0", bus.d_out); end
        bus.net_ro = 1'b0;
        cpu_read(2'b00, r);
        vectors++; if (r !== 64'h0) begin miscompares++; $display("FAIL mid_read got=%h exp=0", r); end
        cpu_read(2'b01, r);
        vectors++; if (r !== stat(1'b0, 1'b1, 8'd0)) begin miscompares++; $display("FAIL mid_in_status got=%h exp=%h", r, stat(1'b0, 1'b1, 8'd0)); end
        cpu_read(2'b11, r);
        vectors++; if (r !== 64'h0) begin miscompares++; $display("FAIL mid_out_status got=%h exp=0", r); end
    endtask

    initial begin
        test_reset();
        test_input_fill();
        test_inject();
        test_out_full();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
